alu_ctrl_decode: RTL

- Decode stage for the RV32I core: the producing end of the ALU control interface.
- Takes a fetched instruction and its PC through a valid/ready handshake.
- Decodes alu_sel (the `ALU_* codes in definitions.sv), operand selects, immediate and control flags.
- Holds the result in a one-entry ID/EX pipeline register that drives the ALU and execute stage.

---
 rtl/alu_ctrl_decode.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_decode.sv
// RV32I decode stage: decodes one instruction into an ALU control bundle held in a one-entry ID/EX register.
// Optional: define DECODE_ILLEGAL_EN to drive illegal=1 for undecodable encodings (otherwise tied 0).
module alu_ctrl_decode #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_sel,
  output logic            a_sel,
  output logic            b_sel,
  output logic [XLEN-1:0] imm,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            reg_we,
  output logic            mem_re,
  output logic            mem_we,
  output logic            is_branch,
  output logic            br_inv,
  output logic            is_jump,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;
  localparam logic [3:0] ALU_SEQ  = 4'd11;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Shared register/immediate arithmetic table; alt selects SUB/SRA.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_sh = {27'b0, in_instr[24:20]};

  logic [3:0]  d_alu_sel;
  logic        d_a_sel, d_b_sel;
  logic [31:0] d_imm;
  logic        d_reg_we, d_mem_re, d_mem_we;
  logic        d_is_branch, d_br_inv, d_is_jump;
  logic        d_illegal;

  // Combinational decode of the incoming instruction.
  always_comb begin
    d_alu_sel   = ALU_ADD;
    d_a_sel     = 1'b0;
    d_b_sel     = 1'b0;
    d_imm       = 32'b0;
    d_reg_we    = 1'b0;
    d_mem_re    = 1'b0;
    d_mem_we    = 1'b0;
    d_is_branch = 1'b0;
    d_br_inv    = 1'b0;
    d_is_jump   = 1'b0;
    d_illegal   = 1'b0;

    unique case (opcode)
      OPC_OP: begin
        d_reg_we = 1'b1;
        if (funct7 == F7_ZERO)
          d_alu_sel = arith_op(funct3, 1'b0);
        else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))
          d_alu_sel = arith_op(funct3, 1'b1);
        else
          d_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        d_reg_we = 1'b1;
        d_b_sel  = 1'b1;
        d_imm    = imm_i;
        if (funct3 == 3'b001) begin
          d_alu_sel = ALU_SLL;
          d_imm     = imm_sh;
          d_illegal = (funct7 != F7_ZERO);
        end else if (funct3 == 3'b101) begin
          d_imm = imm_sh;
          if (funct7 == F7_ZERO)     d_alu_sel = ALU_SRL;
          else if (funct7 == F7_ALT) d_alu_sel = ALU_SRA;
          else                       d_illegal = 1'b1;
        end else begin
          d_alu_sel = arith_op(funct3, 1'b0);
        end
      end
      OPC_LOAD: begin
        d_b_sel   = 1'b1;
        d_imm     = imm_i;
        d_mem_re  = 1'b1;
        d_reg_we  = 1'b1;
        d_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        d_b_sel   = 1'b1;
        d_imm     = imm_s;
        d_mem_we  = 1'b1;
        d_illegal = (funct3[2] == 1'b1) || (funct3 == 3'b011);
      end
      OPC_LUI: begin
        d_alu_sel = ALU_PASS;
        d_b_sel   = 1'b1;
        d_imm     = imm_u;
        d_reg_we  = 1'b1;
      end
      OPC_AUIPC: begin
        d_a_sel  = 1'b1;
        d_b_sel  = 1'b1;
        d_imm    = imm_u;
        d_reg_we = 1'b1;
      end
      OPC_JAL: begin
        d_a_sel   = 1'b1;
        d_b_sel   = 1'b1;
        d_imm     = imm_j;
        d_is_jump = 1'b1;
        d_reg_we  = 1'b1;
      end
      OPC_JALR: begin
        d_b_sel   = 1'b1;
        d_imm     = imm_i;
        d_is_jump = 1'b1;
        d_reg_we  = 1'b1;
        d_illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        d_imm       = imm_b;
        d_is_branch = 1'b1;
        unique case (funct3)
          3'b000:  d_alu_sel = ALU_SEQ;
          3'b001:  d_alu_sel = ALU_XOR;
          3'b100:  d_alu_sel = ALU_SLT;
          3'b101: begin d_alu_sel = ALU_SLT;  d_br_inv = 1'b1; end
          3'b110:  d_alu_sel = ALU_SLTU;
          3'b111: begin d_alu_sel = ALU_SLTU; d_br_inv = 1'b1; end
          default: d_illegal = 1'b1;
        endcase
      end
      default: d_illegal = 1'b1;
    endcase

    // Undecodable encodings collapse to a NOP bundle.
    if (d_illegal) begin
      d_alu_sel   = ALU_ADD;
      d_a_sel     = 1'b0;
      d_b_sel     = 1'b0;
      d_imm       = 32'b0;
      d_reg_we    = 1'b0;
      d_mem_re    = 1'b0;
      d_mem_we    = 1'b0;
      d_is_branch = 1'b0;
      d_br_inv    = 1'b0;
      d_is_jump   = 1'b0;
    end
    if (in_instr[11:7] == 5'd0) d_reg_we = 1'b0;
  end

  assign in_ready = !out_valid || out_ready || flush;

  logic load;
  assign load = in_valid && in_ready && !flush;

  // ID/EX register: flush wins, then a new load, then drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_sel   <= 4'd0;
      a_sel     <= 1'b0;
      b_sel     <= 1'b0;
      imm       <= '0;
      rs1       <= 5'd0;
      rs2       <= 5'd0;
      rd        <= 5'd0;
      reg_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      is_branch <= 1'b0;
      br_inv    <= 1'b0;
      is_jump   <= 1'b0;
      pc_out    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      alu_sel   <= d_alu_sel;
      a_sel     <= d_a_sel;
      b_sel     <= d_b_sel;
      imm       <= XLEN'($signed(d_imm));
      rs1       <= in_instr[19:15];
      rs2       <= in_instr[24:20];
      rd        <= in_instr[11:7];
      reg_we    <= d_reg_we;
      mem_re    <= d_mem_re;
      mem_we    <= d_mem_we;
      is_branch <= d_is_branch;
      br_inv    <= d_br_inv;
      is_jump   <= d_is_jump;
      pc_out    <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_ILLEGAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    illegal <= 1'b0;
    else if (load) illegal <= d_illegal;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule
